// File: rtl/pinwheel_pkg.sv
// Shared types and constants for the pinwheel barrel-core hart scheduler.
package pinwheel_pkg;

  typedef enum logic [1:0] {
    PARKED   = 2'd0,
    READY    = 2'd1,
    INFLIGHT = 2'd2
  } hart_state_e;

  localparam int HPC_HART_W = 4;
  localparam int HPC_PC_W   = 32;

  // Widest hart/PC pair the scheduler supports: 16 harts, 32-bit PCs.
  typedef struct packed {
    logic [HPC_HART_W-1:0] hart;
    logic [HPC_PC_W-1:0]   pc;
  } hpc_t;

  localparam logic [HPC_PC_W-1:0] HPC_PARKED = '0;

endpackage

// File: rtl/pinwheel_rr_arbiter.sv
// Round-robin pick: the first set request at or after ptr+1, wrapping modulo N.
module pinwheel_rr_arbiter #(
  parameter  int N  = 8,
  localparam int HB = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [HB-1:0] ptr,
  output logic          gnt_valid,
  output logic [HB-1:0] gnt_idx
);

  logic [HB-1:0] base;
  logic [N-1:0]  rot;
  logic [HB-1:0] off;

  assign base = ptr + HB'(1);

  // N is a power of two, so HB-bit index arithmetic wraps for free.
  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = req[base + HB'(i)];
    end
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = HB'(i);
    end
  end

  assign gnt_valid = |req;
  assign gnt_idx   = base + off;

endmodule

// File: rtl/pinwheel_hart_sched.sv
// Barrel-core hart scheduler: per-hart PC/state, round-robin fetch issue with stall hold,
// stage-B redirects and stage-C cross-hart starts.
module pinwheel_hart_sched
  import pinwheel_pkg::*;
#(
  parameter  int                  NUM_HARTS  = 8,
  parameter  int                  PC_WIDTH   = 24,
  parameter  logic [PC_WIDTH-1:0] RESET_PC   = 'h400000,
  parameter  int                  RESET_HART = 0,
  localparam int                  HART_BITS  = $clog2(NUM_HARTS)
) (
  input  logic                 clock,
  input  logic                 reset_in,
  output logic                 issue_valid,
  input  logic                 issue_ready,
  output logic [HART_BITS-1:0] issue_hart,
  output logic [PC_WIDTH-1:0]  issue_pc,
  input  logic                 redirect_valid,
  input  logic [HART_BITS-1:0] redirect_hart,
  input  logic [PC_WIDTH-1:0]  redirect_pc,
  input  logic                 start_valid,
  input  logic [HART_BITS-1:0] start_hart,
  input  logic [PC_WIDTH-1:0]  start_pc,
  output logic                 start_busy,
  output logic [NUM_HARTS-1:0] active_mask,
  output logic                 idle,
  output logic                 proto_err,
  output logic [31:0]          issue_count
);

  hart_state_e          state_q [NUM_HARTS];
  logic [PC_WIDTH-1:0]  pc_q    [NUM_HARTS];
  logic [HART_BITS-1:0] ptr_q;
  logic [HART_BITS-1:0] hold_hart_q;
  logic                 hold_vld_q;
  logic                 proto_err_q;
  logic [31:0]          issue_count_q;

  logic [NUM_HARTS-1:0] ready_vec;
  logic                 any_ready;
  logic [HART_BITS-1:0] pick_hart;
  logic [HART_BITS-1:0] sel_hart;
  logic                 issue_go;
  logic                 accept;
  logic                 redir_legal;
  logic                 redir_parks;
  logic                 start_target_parked;
  logic                 start_take;

  always_comb begin
    ready_vec   = '0;
    active_mask = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      ready_vec[h]   = (state_q[h] == READY);
      active_mask[h] = (state_q[h] != PARKED);
    end
  end

  pinwheel_rr_arbiter #(.N(NUM_HARTS)) u_arb (
    .req       (ready_vec),
    .ptr       (ptr_q),
    .gnt_valid (any_ready),
    .gnt_idx   (pick_hart)
  );

  // A stalled hart stays READY (redirects and starts cannot touch it), so holding
  // only its index also keeps issue_pc stable.
  assign sel_hart    = hold_vld_q ? hold_hart_q : pick_hart;
  assign issue_go    = any_ready && !reset_in;
  assign issue_valid = issue_go;
  assign issue_hart  = issue_go ? sel_hart : '0;
  assign issue_pc    = issue_go ? pc_q[sel_hart] : '0;
  assign accept      = issue_go && issue_ready;

  assign redir_legal = redirect_valid && (state_q[redirect_hart] == INFLIGHT);
  assign redir_parks = redir_legal && (redirect_pc == PC_WIDTH'(HPC_PARKED));

  // A start landing on a hart that is being parked this same cycle takes effect.
  assign start_target_parked = (state_q[start_hart] == PARKED) ||
                               (redir_parks && (redirect_hart == start_hart));
  assign start_take = start_valid && start_target_parked && (start_pc != PC_WIDTH'(HPC_PARKED));
  assign start_busy = start_valid && !start_target_parked && !reset_in;

  assign idle        = &(~active_mask);
  assign proto_err   = proto_err_q;
  assign issue_count = issue_count_q;

  always_ff @(posedge clock) begin
    if (reset_in) begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        state_q[h] <= (h == RESET_HART) ? READY : PARKED;
        pc_q[h]    <= (h == RESET_HART) ? RESET_PC : '0;
      end
      ptr_q         <= HART_BITS'(RESET_HART + NUM_HARTS - 1);
      hold_vld_q    <= 1'b0;
      hold_hart_q   <= '0;
      proto_err_q   <= 1'b0;
      issue_count_q <= '0;
    end else begin
      if (redirect_valid && !redir_legal) proto_err_q <= 1'b1;
      if (redir_legal) begin
        pc_q[redirect_hart]    <= redirect_pc;
        state_q[redirect_hart] <= redir_parks ? PARKED : READY;
      end
      if (start_take) begin
        pc_q[start_hart]    <= start_pc;
        state_q[start_hart] <= READY;
      end
      if (accept) begin
        state_q[sel_hart] <= INFLIGHT;
        ptr_q             <= sel_hart;
        issue_count_q     <= issue_count_q + 32'd1;
      end
      hold_vld_q  <= issue_go && !issue_ready;
      hold_hart_q <= sel_hart;
    end
  end

endmodule
